// File: rtl/sd_uart_sequencer.sv
// UART command sequencer for SdCardCtrl block reads/writes.
// Parses 'r'/'w' + LBA, runs the four-phase byte handshake, ends with a status byte.
module sd_uart_sequencer #(
  parameter int BLOCK_SIZE     = 512,
  parameter int TIMEOUT_CYCLES = 27000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_addr,
  output logic [7:0]  sd_wdata,
  input  logic [7:0]  sd_rdata,
  input  logic        sd_busy,
  input  logic        sd_hs_ctrl,
  output logic        sd_hs_host,
  output logic        cmd_active,
  output logic [7:0]  status_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [9:0]    LAST_BYTE = 10'(BLOCK_SIZE - 1);

  localparam logic [7:0] CMD_R  = 8'h72;
  localparam logic [7:0] CMD_W  = 8'h77;
  localparam logic [7:0] ST_OK  = 8'h4B;
  localparam logic [7:0] ST_TMO = 8'h54;
  localparam logic [7:0] ST_OVR = 8'h4F;
  localparam logic [7:0] ST_UNK = 8'h3F;
  localparam logic [7:0] ST_BSY = 8'h42;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_TX,
    S_RD_TXW,
    S_RD_ACK,
    S_WR_REQ,
    S_WR_DATA,
    S_WR_HI,
    S_WR_LO,
    S_DONE,
    S_ABORT,
    S_ST_SEND,
    S_ST_WAIT
  } state_t;

  state_t        r_state;
  logic          r_is_wr;
  logic [1:0]    r_acnt;
  logic [9:0]    r_cnt;
  logic [7:0]    r_data;
  logic [7:0]    r_hold;
  logic          r_full;
  logic [7:0]    r_stat;
  logic [TW-1:0] r_tmo;
  logic          r_busy_q;
  logic          r_hs_q;

  logic       w_progress;
  logic       w_tmo;
  logic       w_is_cmd;
  logic       w_wr_phase;
  logic       w_data_wait;
  logic       w_overrun;
  logic       w_abort;
  logic [7:0] w_abort_code;

  assign w_progress = rx_valid | tx_done
                    | (sd_busy ^ r_busy_q)
                    | (sd_hs_ctrl ^ r_hs_q);
  assign w_tmo    = (r_tmo == TMO_LAST);
  assign w_is_cmd = (rx_byte == CMD_R) || (rx_byte == CMD_W);

  assign w_wr_phase = r_state inside
    {S_WR_REQ, S_WR_DATA, S_WR_HI, S_WR_LO};
  assign w_data_wait = r_state inside
    {S_ADDR, S_RD_REQ, S_RD_WAIT, S_RD_TX,
     S_RD_TXW, S_RD_ACK, S_WR_REQ, S_WR_DATA,
     S_WR_HI, S_WR_LO, S_DONE};

  // The slot frees in the same cycle the handshake closes, so a byte then is legal
  assign w_overrun = w_wr_phase && rx_valid && r_full
                  && !(r_state == S_WR_LO && !sd_hs_ctrl);
  assign w_abort = w_overrun || (w_data_wait && w_tmo);

  always_comb begin
    w_abort_code = ST_TMO;
    unique case (1'b1)
      w_overrun: w_abort_code = ST_OVR;
      default:   w_abort_code = ST_TMO;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_is_wr    <= 1'b0;
      r_acnt     <= '0;
      r_cnt      <= '0;
      r_data     <= '0;
      r_hold     <= '0;
      r_full     <= 1'b0;
      r_stat     <= '0;
      r_tmo      <= '0;
      r_busy_q   <= 1'b0;
      r_hs_q     <= 1'b0;
      tx_dv      <= 1'b0;
      tx_byte    <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      sd_addr    <= '0;
      sd_wdata   <= '0;
      sd_hs_host <= 1'b0;
      cmd_active <= 1'b0;
      status_o   <= '0;
    end else begin
      tx_dv    <= 1'b0;
      r_busy_q <= sd_busy;
      r_hs_q   <= sd_hs_ctrl;

      if (r_state == S_IDLE || w_progress) begin
        r_tmo <= '0;
      end else if (!w_tmo) begin
        r_tmo <= r_tmo + TMO_ONE;
      end

      if (w_wr_phase && rx_valid && !r_full) begin
        r_hold <= rx_byte;
        r_full <= 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_acnt <= '0;
          r_full <= 1'b0;
          if (rx_valid) begin
            if (w_is_cmd && !sd_busy) begin
              cmd_active <= 1'b1;
              r_is_wr    <= (rx_byte == CMD_W);
              r_state    <= S_ADDR;
            end else if (w_is_cmd) begin
              r_stat  <= ST_BSY;
              r_state <= S_ST_SEND;
            end else begin
              r_stat  <= ST_UNK;
              r_state <= S_ST_SEND;
            end
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            sd_addr <= {sd_addr[23:0], rx_byte};
            r_acnt  <= r_acnt + 2'd1;
            if (r_acnt == 2'd3) begin
              if (r_is_wr) begin
                sd_wr   <= 1'b1;
                r_state <= S_WR_REQ;
              end else begin
                sd_rd   <= 1'b1;
                r_state <= S_RD_REQ;
              end
            end
          end
        end
        S_RD_REQ: begin
          if (sd_busy) begin
            sd_rd   <= 1'b0;
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (sd_hs_ctrl) begin
            r_data  <= sd_rdata;
            r_state <= S_RD_TX;
          end
        end
        S_RD_TX: begin
          if (!tx_active) begin
            tx_dv   <= 1'b1;
            tx_byte <= r_data;
            r_state <= S_RD_TXW;
          end
        end
        S_RD_TXW: begin
          if (tx_done) begin
            sd_hs_host <= 1'b1;
            r_state    <= S_RD_ACK;
          end
        end
        S_RD_ACK: begin
          if (!sd_hs_ctrl) begin
            sd_hs_host <= 1'b0;
            r_cnt      <= r_cnt + 10'd1;
            r_state    <= (r_cnt == LAST_BYTE) ? S_DONE : S_RD_WAIT;
          end
        end
        S_WR_REQ: begin
          if (sd_busy) begin
            sd_wr   <= 1'b0;
            r_state <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (r_full) begin
            sd_wdata   <= r_hold;
            sd_hs_host <= 1'b1;
            r_state    <= S_WR_HI;
          end
        end
        S_WR_HI: begin
          if (sd_hs_ctrl) begin
            sd_hs_host <= 1'b0;
            r_state    <= S_WR_LO;
          end
        end
        S_WR_LO: begin
          if (!sd_hs_ctrl) begin
            r_full <= rx_valid && (r_cnt != LAST_BYTE);
            if (rx_valid) r_hold <= rx_byte;
            r_cnt   <= r_cnt + 10'd1;
            r_state <= (r_cnt == LAST_BYTE) ? S_DONE : S_WR_DATA;
          end
        end
        S_DONE: begin
          if (!sd_busy) begin
            r_stat  <= ST_OK;
            r_state <= S_ST_SEND;
          end
        end
        S_ABORT: begin
          if (!sd_busy || w_tmo) begin
            r_tmo   <= '0;
            r_state <= S_ST_SEND;
          end
        end
        S_ST_SEND: begin
          if (!tx_active) begin
            tx_dv    <= 1'b1;
            tx_byte  <= r_stat;
            status_o <= r_stat;
            r_state  <= S_ST_WAIT;
          end else if (w_tmo) begin
            cmd_active <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_ST_WAIT: begin
          if (tx_done || w_tmo) begin
            cmd_active <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Abort overrides whatever the data states scheduled this cycle
      if (w_abort) begin
        r_stat     <= w_abort_code;
        sd_rd      <= 1'b0;
        sd_wr      <= 1'b0;
        sd_hs_host <= 1'b0;
        tx_dv      <= 1'b0;
        r_full     <= 1'b0;
        r_tmo      <= '0;
        r_state    <= S_ABORT;
      end
    end
  end

endmodule

// File: tb/tb_sd_uart_sequencer.sv
// Scoreboard bench for sd_uart_sequencer with UART TX and SdCardCtrl models.
// TX bytes are checked by a monitor against an expectation queue.
module tb_sd_uart_sequencer;

  localparam int BS  = 512;
  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;
  logic        sd_rd;
  logic        sd_wr;
  logic [31:0] sd_addr;
  logic [7:0]  sd_wdata;
  logic [7:0]  sd_rdata = 8'h00;
  logic        m_busy = 1'b0;
  logic        ext_busy = 1'b0;
  wire         w_busy = m_busy | ext_busy;
  logic        sd_hs_ctrl = 1'b0;
  logic        sd_hs_host;
  logic        cmd_active;
  logic [7:0]  status_o;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] wr_q[$];
  int n_rd = 0;
  int n_wr = 0;
  int rd_idx = -1;
  bit kill = 0;
  bit stall = 0;
  bit never_hs = 0;
  bit m_rd = 0;

  sd_uart_sequencer #(.BLOCK_SIZE(BS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_dv(tx_dv), .tx_byte(tx_byte),
    .tx_active(tx_active), .tx_done(tx_done),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_addr(sd_addr),
    .sd_wdata(sd_wdata), .sd_rdata(sd_rdata),
    .sd_busy(w_busy), .sd_hs_ctrl(sd_hs_ctrl),
    .sd_hs_host(sd_hs_host), .cmd_active(cmd_active),
    .status_o(status_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    step();
    rx_byte  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] a);
    send(c);
    for (int i = 3; i >= 0; i--) send(a[i*8 +: 8]);
  endtask

  task automatic push_rd();
    for (int i = 0; i < BS; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h4B);
  endtask

  task automatic wait_host(input logic v);
    while (sd_hs_host !== v && !kill) step();
  endtask

  task automatic wait_cmd_low(input int budget, output int cyc);
    cyc = 0;
    while (cmd_active && cyc < budget) begin
      step();
      cyc++;
    end
    check("cmd_done", {31'd0, cmd_active}, 32'd0);
  endtask

  // UART TX model
  initial forever begin
    step();
    if (tx_dv) begin
      tx_active = 1'b1;
      repeat (3) step();
      tx_done   = 1'b1;
      tx_active = 1'b0;
      step();
      tx_done = 1'b0;
    end
  end

  // TX monitor
  initial forever begin
    @(negedge clk);
    if (rstn && tx_dv) begin
      if (exp_q.size() == 0) begin
        check("tx_unexpected", {24'd0, tx_byte}, 32'hFFFF_FFFF);
      end else begin
        check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // SdCardCtrl model
  initial forever begin
    step();
    if (kill) begin
      m_busy     = 1'b0;
      sd_hs_ctrl = 1'b0;
    end else if (sd_rd || sd_wr) begin
      m_rd = sd_rd;
      if (m_rd) n_rd++;
      else n_wr++;
      m_busy = 1'b1;
      step();
      if (never_hs) begin
        while (!kill) step();
      end else if (m_rd) begin
        for (int i = 0; i < BS && !kill; i++) begin
          rd_idx     = i;
          sd_rdata   = 8'(i);
          sd_hs_ctrl = 1'b1;
          wait_host(1'b1);
          sd_hs_ctrl = 1'b0;
          wait_host(1'b0);
        end
      end else begin
        for (int i = 0; i < BS && !kill; i++) begin
          wait_host(1'b1);
          if (kill) break;
          wr_q.push_back(sd_wdata);
          if (stall) while (!kill) step();
          if (kill) break;
          sd_hs_ctrl = 1'b1;
          wait_host(1'b0);
          sd_hs_ctrl = 1'b0;
        end
      end
      sd_hs_ctrl = 1'b0;
      if (!kill) repeat (3) step();
      m_busy = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int b;
    repeat (3) step();
    check("rst_tx_dv", {31'd0, tx_dv}, 32'd0);
    check("rst_sd_rd", {31'd0, sd_rd}, 32'd0);
    check("rst_sd_wr", {31'd0, sd_wr}, 32'd0);
    check("rst_addr", sd_addr, 32'd0);
    check("rst_hs_host", {31'd0, sd_hs_host}, 32'd0);
    check("rst_cmd_active", {31'd0, cmd_active}, 32'd0);
    check("rst_status", {24'd0, status_o}, 32'd0);
    rstn = 1'b1;
    repeat (3) step();

    push_rd();
    send_cmd(8'h72, 32'h0000_0005);
    check("rd_addr", sd_addr, 32'h5);
    check("rd_cmd_active", {31'd0, cmd_active}, 32'd1);
    wait_cmd_low(20000, cyc);
    check("rd_nreq", n_rd, 1);
    check("rd_status", {24'd0, status_o}, 32'h4B);
    check("rd_q_empty", exp_q.size(), 0);

    exp_q.push_back(8'h4B);
    send_cmd(8'h77, 32'h0000_0100);
    check("wr_addr", sd_addr, 32'h100);
    repeat (20) step();
    for (int i = 0; i < BS; i++) begin
      send(8'(i));
      repeat (20) step();
    end
    wait_cmd_low(5000, cyc);
    check("wr_nreq", n_wr, 1);
    check("wr_status", {24'd0, status_o}, 32'h4B);
    check("wr_count", wr_q.size(), BS);
    for (int i = 0; i < wr_q.size(); i++)
      check("wr_data", {24'd0, wr_q[i]}, i & 255);
    wr_q.delete();

    exp_q.push_back(8'h3F);
    send(8'h78);
    repeat (20) step();
    check("unk_status", {24'd0, status_o}, 32'h3F);
    check("unk_no_rd", n_rd, 1);
    check("unk_no_wr", n_wr, 1);
    check("unk_cmd_active", {31'd0, cmd_active}, 32'd0);

    ext_busy = 1'b1;
    exp_q.push_back(8'h42);
    send(8'h72);
    repeat (20) step();
    ext_busy = 1'b0;
    check("bsy_status", {24'd0, status_o}, 32'h42);
    check("bsy_no_rd", n_rd, 1);

    stall = 1'b1;
    exp_q.push_back(8'h4F);
    send_cmd(8'h77, 32'h0000_0007);
    repeat (20) step();
    send(8'h00);
    repeat (20) step();
    check("ovr_hs_up", {31'd0, sd_hs_host}, 32'd1);
    send(8'h01);
    repeat (3) step();
    check("ovr_hs_drop", {31'd0, sd_hs_host}, 32'd0);
    check("ovr_wr_low", {31'd0, sd_wr}, 32'd0);
    wait_cmd_low(5000, cyc);
    check("ovr_status", {24'd0, status_o}, 32'h4F);
    kill = 1'b1;
    repeat (5) step();
    kill = 1'b0;
    stall = 1'b0;
    wr_q.delete();
    check("ovr_nreq", n_wr, 2);

    never_hs = 1'b1;
    exp_q.push_back(8'h54);
    send_cmd(8'h72, 32'h0000_0009);
    wait_cmd_low(5000, cyc);
    check("tmo_status", {24'd0, status_o}, 32'h54);
    if (cyc < TMO || cyc > 2200)
      check("tmo_cycles", cyc, TMO);
    else
      check("tmo_cycles", 32'(cyc >= TMO), 32'd1);
    kill = 1'b1;
    repeat (5) step();
    kill = 1'b0;
    never_hs = 1'b0;

    push_rd();
    send_cmd(8'h72, 32'h0000_0003);
    b = 0;
    while (rd_idx != 100 && b < 10000) begin
      @(posedge clk);
      #2;
      b++;
    end
    check("mid_reach100", rd_idx, 100);
    rstn = 1'b0;
    kill = 1'b1;
    #1;
    check("mid_tx_dv", {31'd0, tx_dv}, 32'd0);
    check("mid_tx_byte", {24'd0, tx_byte}, 32'd0);
    check("mid_sd_rd", {31'd0, sd_rd}, 32'd0);
    check("mid_addr", sd_addr, 32'd0);
    check("mid_wdata", {24'd0, sd_wdata}, 32'd0);
    check("mid_hs_host", {31'd0, sd_hs_host}, 32'd0);
    check("mid_cmd_active", {31'd0, cmd_active}, 32'd0);
    exp_q.delete();
    repeat (5) step();
    rstn = 1'b1;
    kill = 1'b0;
    repeat (10) step();
    check("mid_no_status", {24'd0, status_o}, 32'd0);

    push_rd();
    send_cmd(8'h72, 32'h0000_0011);
    check("re_addr", sd_addr, 32'h11);
    wait_cmd_low(20000, cyc);
    check("re_status", {24'd0, status_o}, 32'h4B);
    check("re_nreq", n_rd, 4);
    check("re_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
